control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 30 +++
 rtl/control.sv | 143 ++++++++++++++
 tb/tb_control.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// control_pkg -- shared definitions for the MixColumns sequencer.
//
// Contents:
//   state_e    FSM state encoding (IDLE, RUN, DONE)
//   PASS_LEN   number of RUN cycles in one pass (4 cols x 4 rows x 4 terms)
//   Y_TABLE    MixColumns coefficient matrix, row-major, entry 4*row+k
//   y_coef()   coefficient lookup for a (row, k) pair
package control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int PASS_LEN = 64;

  // Row-major: index 0 is row 0, term 0.
  localparam logic [0:15][1:0] Y_TABLE = {
    2'd2, 2'd3, 2'd1, 2'd1,
    2'd1, 2'd2, 2'd3, 2'd1,
    2'd1, 2'd1, 2'd2, 2'd3,
    2'd3, 2'd1, 2'd1, 2'd2
  };

  function automatic logic [1:0] y_coef(input logic [1:0] row, input logic [1:0] k);
    return Y_TABLE[{row, k}];
  endfunction

endpackage

// File: rtl/control.sv
// control -- sequences one AES MixColumns pass through an external
// GF(2^8) multiply-accumulate unit (func_unit), one term per cycle.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   start               begin a pass (sampled in IDLE only)
//   state0..state3      input columns; byte 0 of a column is bits [31:24]
//   fu_result           func_unit result: fu_s ^ gfmul(fu_y, fu_state)
//   fu_s                accumulator byte to func_unit
//   fu_state            operand byte to func_unit
//   fu_y                coefficient to func_unit (1, 2 or 3; 0 when idle)
//   state_out0..3       result columns, same byte order as the inputs
//   done                one-cycle pulse after the last result byte
module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  input  logic [7:0]  fu_result,
  output logic [7:0]  fu_s,
  output logic [7:0]  fu_state,
  output logic [1:0]  fu_y,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        done
);

  state_e      state_q, state_d;
  // {col, row, k}: a plain binary increment walks k innermost, col outermost.
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  in_q  [4][4];  // [col][byte]
  logic [7:0]  out_q [4][4];  // [col][row]
  logic        load_in;
  logic        wr_out;

  logic [1:0]  col, row, k;
  logic [31:0] in_word [4];

  assign col = cnt_q[5:4];
  assign row = cnt_q[3:2];
  assign k   = cnt_q[1:0];

  assign in_word[0] = state0;
  assign in_word[1] = state1;
  assign in_word[2] = state2;
  assign in_word[3] = state3;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    load_in  = 1'b0;
    wr_out   = 1'b0;
    fu_s     = '0;
    fu_state = '0;
    fu_y     = '0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_in = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        fu_s     = acc_q;
        fu_state = in_q[col][k];
        fu_y     = y_coef(row, k);
        cnt_d    = cnt_q + 6'd1;
        if (k == 2'd3) begin
          // Last term of this output byte: commit it and restart the sum.
          wr_out = 1'b1;
          acc_d  = '0;
        end else begin
          acc_d  = fu_result;
        end
        if (cnt_q == 6'(PASS_LEN - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      // NOTE: these arrays are plain registers, not RAM, so they take the
      // reset; the result words must read zero after reset.
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          in_q[c][r]  <= '0;
          out_q[c][r] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (load_in) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            in_q[c][r] <= in_word[c][31-8*r -: 8];
          end
        end
      end
      if (wr_out) begin
        out_q[col][row] <= fu_result;
      end
    end
  end

  assign state_out0 = {out_q[0][0], out_q[0][1], out_q[0][2], out_q[0][3]};
  assign state_out1 = {out_q[1][0], out_q[1][1], out_q[1][2], out_q[1][3]};
  assign state_out2 = {out_q[2][0], out_q[2][1], out_q[2][2], out_q[2][3]};
  assign state_out3 = {out_q[3][0], out_q[3][1], out_q[3][2], out_q[3][3]};

endmodule

// File: tb/tb_control.sv
// tb_control -- scoreboard bench for control with a behavioural func_unit.
module tb_control;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] state0, state1, state2, state3;
  logic [7:0]  fu_result;
  logic [7:0]  fu_s;
  logic [7:0]  fu_state;
  logic [1:0]  fu_y;
  logic [31:0] state_out0, state_out1, state_out2, state_out3;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [127:0] exp_q[$];   // {out0, out1, out2, out3} per expected done
  logic [127:0] mon_exp;

  int ytab[16] = '{2, 3, 1, 1, 1, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 2};

  localparam logic [127:0] EXP_A = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] EXP_B = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000, 32'h00000000};

  control dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .state0     (state0),
    .state1     (state1),
    .state2     (state2),
    .state3     (state3),
    .fu_result  (fu_result),
    .fu_s       (fu_s),
    .fu_state   (fu_state),
    .fu_y       (fu_y),
    .state_out0 (state_out0),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fmul(input logic [1:0] y, input logic [7:0] x);
    case (y)
      2'd1:    return x;
      2'd2:    return xtime(x);
      2'd3:    return xtime(x) ^ x;
      default: return 8'h00;
    endcase
  endfunction

  // func_unit model
  assign fu_result = fu_s ^ fmul(fu_y, fu_state);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] a, b, c, d);
    state0 = a;
    state1 = b;
    state2 = c;
    state3 = d;
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("state_out0", state_out0, mon_exp[127:96]);
        check("state_out1", state_out1, mon_exp[95:64]);
        check("state_out2", state_out2, mon_exp[63:32]);
        check("state_out3", state_out3, mon_exp[31:0]);
      end
    end
  end

  // One pass with start pulsed for one cycle; optionally traces fu_* each RUN cycle.
  task automatic do_pass(input logic [31:0] a, b, c, d, input logic [127:0] exp, input bit trace);
    logic [31:0] sv[4];
    logic [7:0]  acc_m, res_m, byte_m;
    int          lat, idx, col, row, k;
    sv = '{a, b, c, d};
    @(negedge clk);
    set_inputs(a, b, c, d);
    start = 1'b1;
    exp_q.push_back(exp);
    lat   = 0;
    acc_m = 8'h00;
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (trace && i <= 64) begin
        idx    = i - 1;
        col    = idx / 16;
        row    = (idx / 4) % 4;
        k      = idx % 4;
        byte_m = sv[col][31-8*k -: 8];
        check("trace_fu_y", 32'(fu_y), 32'(ytab[4*row+k]));
        check("trace_fu_state", 32'(fu_state), 32'(byte_m));
        check("trace_fu_s", 32'(fu_s), 32'(acc_m));
        res_m = acc_m ^ fmul(2'(ytab[4*row+k]), byte_m);
        acc_m = (k == 3) ? 8'h00 : res_m;
      end
      if (done) lat = i;
    end
    check("done_latency", 32'(lat), 32'd65);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, d1, d2;

    reset = 1'b1;
    start = 1'b0;
    set_inputs(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_out0", state_out0, 32'h0);
    check("rst_out3", state_out3, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fu_s", 32'(fu_s), 32'd0);
    check("rst_fu_y", 32'(fu_y), 32'd0);
    reset = 1'b0;

    // MixColumns reference vectors.
    do_pass(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, EXP_A, 1'b1);
    check("idle_fu_state", 32'(fu_state), 32'd0);
    check("idle_fu_y", 32'(fu_y), 32'd0);
    do_pass(32'hd4d4d4d5, 32'h2d26314c, 32'h0, 32'h0, EXP_B, 1'b0);
    // Results hold after the pass.
    repeat (3) @(negedge clk);
    check("hold_after_done0", state_out0, 32'hd5d5d7d6);
    check("hold_after_done1", state_out1, 32'h4d7ebdf8);
    do_pass(32'h0, 32'h0, 32'h0, 32'h0, 128'h0, 1'b1);

    // start held high: one done per 66 cycles; inputs changed mid-pass are
    // only picked up by the next IDLE.
    @(negedge clk);
    set_inputs(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    start = 1'b1;
    exp_q.push_back(EXP_A);
    exp_q.push_back(EXP_B);
    n_done = 0;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 145; i++) begin
      @(negedge clk);
      if (i == 10)  set_inputs(32'hd4d4d4d5, 32'h2d26314c, 32'h0, 32'h0);
      if (i == 100) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) d1 = i;
        else if (n_done == 2) d2 = i;
      end
    end
    check("held_done_count", 32'(n_done), 32'd2);
    check("held_first_latency", 32'(d1), 32'd65);
    check("held_done_gap", 32'(d2 - d1), 32'd66);

    // Reset at RUN cycle 30 clears everything without a clock edge.
    @(negedge clk);
    set_inputs(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    check("abort_partial_written", 32'(state_out0 != 32'h0), 32'd1);
    check("abort_in_run", 32'(fu_y != 2'd0), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_out0", state_out0, 32'h0);
    check("abort_out1", state_out1, 32'h0);
    check("abort_out2", state_out2, 32'h0);
    check("abort_out3", state_out3, 32'h0);
    check("abort_fu_s", 32'(fu_s), 32'd0);
    check("abort_fu_state", 32'(fu_state), 32'd0);
    check("abort_fu_y", 32'(fu_y), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    do_pass(32'hd4d4d4d5, 32'h2d26314c, 32'h0, 32'h0, EXP_B, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
